// File: rtl/phy_rx_lane_arbiter.sv
// phy_rx_lane_arbiter: round-robin, burst-limited arbiter that moves one
// granted lane word per cycle into a registered output stage with
// downstream backpressure, plus a saturating delivered-word counter.
module phy_rx_lane_arbiter #(
    parameter int DATA_W    = 32,
    parameter int NUM_LANES = 4,
    parameter int MAX_BURST = 4,
    parameter int LANE_W    = 2
) (
    input  logic                          clk_Arb,
    input  logic                          reset,
    input  logic                          enable_Arb,
    input  logic [NUM_LANES-1:0]          valid_in_Arb,
    input  logic [NUM_LANES*DATA_W-1:0]   data_in_Arb,
    output logic [NUM_LANES-1:0]          ready_out_Arb,
    input  logic                          ready_in_Arb,
    output logic                          valid_out_Arb,
    output logic [DATA_W-1:0]             data_out_Arb,
    output logic [LANE_W-1:0]             lane_out_Arb,
    output logic [15:0]                   word_cnt_Arb
);

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

    state_t              state_q, state_d;
    logic [LANE_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [LANE_W-1:0]   cur_lane_q, cur_lane_d;
    logic [3:0]          burst_cnt_q, burst_cnt_d;
    logic                valid_out_q, valid_out_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic [LANE_W-1:0]   lane_out_q, lane_out_d;
    logic [15:0]         word_cnt_q, word_cnt_d;

    logic                can_accept;
    logic [LANE_W-1:0]   sel;
    logic                sel_found;
    logic [LANE_W-1:0]   search_idx;
    logic                xfer;
    logic [LANE_W-1:0]   xfer_lane;
    logic [NUM_LANES-1:0] ready_raw;

    // Lane index after l, wrapping from the last lane back to lane 0.
    function automatic logic [LANE_W-1:0] next_lane(input logic [LANE_W-1:0] l);
        if (int'(l) == NUM_LANES - 1) return '0;
        return l + 1'b1;
    endfunction

    // Round-robin search: first valid lane starting at rr_ptr.
    always_comb begin
        sel        = rr_ptr_q;
        sel_found  = 1'b0;
        search_idx = rr_ptr_q;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (!sel_found && valid_in_Arb[search_idx]) begin
                sel       = search_idx;
                sel_found = 1'b1;
            end
            search_idx = next_lane(search_idx);
        end
    end

    // Grant FSM next state, per-lane ready and output/counter next values.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        cur_lane_d  = cur_lane_q;
        burst_cnt_d = burst_cnt_q;
        ready_raw   = '0;
        xfer        = 1'b0;
        xfer_lane   = cur_lane_q;
        can_accept  = enable_Arb && (!valid_out_q || ready_in_Arb);

        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    ready_raw[sel] = can_accept;
                    xfer           = can_accept;
                    xfer_lane      = sel;
                end
                if (xfer) begin
                    if (MAX_BURST > 1) begin
                        state_d     = BURST;
                        cur_lane_d  = sel;
                        burst_cnt_d = 4'd1;
                    end else begin
                        rr_ptr_d = next_lane(sel);
                    end
                end
            end
            BURST: begin
                ready_raw[cur_lane_q] = can_accept;
                xfer = can_accept && valid_in_Arb[cur_lane_q];
                // Disable or an empty granted lane gives the grant up; the
                // empty-lane case spends this cycle as a bubble.
                if (!enable_Arb || (can_accept && !valid_in_Arb[cur_lane_q])) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_lane(cur_lane_q);
                end else if (xfer) begin
                    burst_cnt_d = burst_cnt_q + 4'd1;
                    if (burst_cnt_q + 4'd1 == BURST_LIMIT) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_lane(cur_lane_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        valid_out_d = valid_out_q;
        data_out_d  = data_out_q;
        lane_out_d  = lane_out_q;
        if (xfer) begin
            valid_out_d = 1'b1;
            data_out_d  = data_in_Arb[xfer_lane*DATA_W +: DATA_W];
            lane_out_d  = xfer_lane;
        end else if (ready_in_Arb) begin
            valid_out_d = 1'b0;
        end

        word_cnt_d = word_cnt_q;
        if (valid_out_q && ready_in_Arb && (word_cnt_q != 16'hFFFF)) begin
            word_cnt_d = word_cnt_q + 16'd1;
        end
    end

    // State, output stage and counter registers with asynchronous reset.
    always_ff @(posedge clk_Arb or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            cur_lane_q  <= '0;
            burst_cnt_q <= '0;
            valid_out_q <= 1'b0;
            data_out_q  <= '0;
            lane_out_q  <= '0;
            word_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cur_lane_q  <= cur_lane_d;
            burst_cnt_q <= burst_cnt_d;
            valid_out_q <= valid_out_d;
            data_out_q  <= data_out_d;
            lane_out_q  <= lane_out_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    // Ready is forced low while reset is asserted.
    always_comb begin
        ready_out_Arb = reset ? '0 : ready_raw;
    end

    assign valid_out_Arb = valid_out_q;
    assign data_out_Arb  = data_out_q;
    assign lane_out_Arb  = lane_out_q;
    assign word_cnt_Arb  = word_cnt_q;

endmodule

// File: tb/tb_phy_rx_lane_arbiter.sv
// Testbench for phy_rx_lane_arbiter: per-lane source queues, expected-word
// scoreboard, one task per scenario.
module tb_phy_rx_lane_arbiter;

    localparam int DATA_W    = 32;
    localparam int NUM_LANES = 4;
    localparam int MAX_BURST = 4;
    localparam int LANE_W    = 2;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic                        en = 1'b0;
    logic [NUM_LANES-1:0]        vin = '0;
    logic [NUM_LANES*DATA_W-1:0] din = '0;
    logic [NUM_LANES-1:0]        rdy_out;
    logic                        rdy_in = 1'b0;
    logic                        vout;
    logic [DATA_W-1:0]           dout;
    logic [LANE_W-1:0]           lane_out;
    logic [15:0]                 wcnt;

    logic [DATA_W-1:0]        src [NUM_LANES][$];
    logic [NUM_LANES-1:0]     lane_on = '1;
    logic [LANE_W+DATA_W-1:0] exp_q [$];
    logic [LANE_W+DATA_W-1:0] obs_q [$];
    int n_tests = 0;
    int n_fail  = 0;

    phy_rx_lane_arbiter #(
        .DATA_W(DATA_W), .NUM_LANES(NUM_LANES), .MAX_BURST(MAX_BURST), .LANE_W(LANE_W)
    ) dut (
        .clk_Arb(clk), .reset(rst), .enable_Arb(en),
        .valid_in_Arb(vin), .data_in_Arb(din), .ready_out_Arb(rdy_out),
        .ready_in_Arb(rdy_in), .valid_out_Arb(vout), .data_out_Arb(dout),
        .lane_out_Arb(lane_out), .word_cnt_Arb(wcnt)
    );

    always #5 clk = ~clk;

    task automatic drive_inputs();
        for (int k = 0; k < NUM_LANES; k++) begin
            vin[k] = lane_on[k] && (src[k].size() > 0);
            din[k*DATA_W +: DATA_W] = '0;
            if (vin[k]) din[k*DATA_W +: DATA_W] = src[k][0];
        end
    endtask

    // One clock: drive lane heads, note which lane transferred and any
    // downstream handshake just before the edge, then retire the word.
    task automatic step(output int fired);
        drive_inputs();
        #1;
        fired = -1;
        for (int k = 0; k < NUM_LANES; k++)
            if (vin[k] && rdy_out[k]) fired = k;
        if (vout && rdy_in) obs_q.push_back({lane_out, dout});
        @(posedge clk);
        #1;
        if (fired >= 0) void'(src[fired].pop_front());
        @(negedge clk);
        drive_inputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < NUM_LANES; k++) src[k].delete();
        exp_q.delete();
        obs_q.delete();
        lane_on = '1;
        en = 1'b1;
        rdy_in = 1'b1;
        drive_inputs();
        rst = 1'b0;
    endtask

    function automatic logic [DATA_W-1:0] word(input int lane, input int j);
        return DATA_W'((lane << 24) | (j & 32'hFF) | 32'h0055_0000);
    endfunction

    task automatic test_reset();
        int f;
        logic [LANE_W+DATA_W-1:0] got, want;
        for (int k = 0; k < NUM_LANES; k++) src[k].push_back(word(k, 0));
        en = 1'b1;
        drive_inputs();
        #1;
        n_tests++;
        if ({vout, dout, lane_out, wcnt, rdy_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_init: vout=%b data=%h lane=%0d cnt=%h rdy=%b, required all 0",
                     vout, dout, lane_out, wcnt, rdy_out);
        end
        do_reset();
        src[0].push_back(word(0, 1));
        rdy_in = 1'b0;
        step(f);
        n_tests++;
        if (vout !== 1'b1 || dout !== word(0, 1)) begin
            n_fail++;
            $display("FAIL reset_preload: vout=%b data=%h, required 1 %h", vout, dout, word(0, 1));
        end
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({vout, dout, lane_out, wcnt, rdy_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_async: vout=%b data=%h lane=%0d cnt=%h rdy=%b, required all 0",
                     vout, dout, lane_out, wcnt, rdy_out);
        end
        @(negedge clk);
        for (int k = 0; k < NUM_LANES; k++) src[k].delete();
        obs_q.delete();
        rst = 1'b0;
        rdy_in = 1'b1;
        src[1].push_back(word(1, 0));
        src[3].push_back(word(3, 0));
        step(f);
        n_tests++;
        if (f !== 1) begin
            n_fail++;
            $display("FAIL reset_first_grant: lane %0d, required 1", f);
        end
        exp_q.push_back({2'd1, word(1, 0)});
        exp_q.push_back({2'd3, word(3, 0)});
        repeat (5) step(f);
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got = 'x;
            if (obs_q.size() > 0) got = obs_q.pop_front();
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL reset_order: got %h required %h", got, want);
            end
        end
    endtask

    task automatic test_single_lane();
        int f, n;
        logic [LANE_W+DATA_W-1:0] got, want;
        do_reset();
        for (int j = 1; j <= 3; j++) begin
            src[2].push_back(32'hA000_0000 + DATA_W'(j));
            exp_q.push_back({2'd2, 32'hA000_0000 + DATA_W'(j)});
        end
        n = 0;
        for (int c = 0; c < 8; c++) begin
            step(f);
            if (f == 2) begin
                n++;
                n_tests++;
                if (vout !== 1'b1 || lane_out !== 2'd2 || dout !== 32'hA000_0000 + DATA_W'(n)) begin
                    n_fail++;
                    $display("FAIL single_latency: vout=%b lane=%0d data=%h, required 1 2 %h",
                             vout, lane_out, dout, 32'hA000_0000 + DATA_W'(n));
                end
            end
        end
        n_tests++;
        if (wcnt !== 16'd3) begin
            n_fail++;
            $display("FAIL single_count: %0d, required 3", wcnt);
        end
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got = 'x;
            if (obs_q.size() > 0) got = obs_q.pop_front();
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL single_order: got %h required %h", got, want);
            end
        end
        n_tests++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL single_extra: %0d extra words, required 0", obs_q.size());
        end
    endtask

    task automatic test_round_robin();
        int f, fires, multi;
        logic [LANE_W+DATA_W-1:0] got, want;
        do_reset();
        for (int k = 0; k < NUM_LANES; k++)
            for (int j = 0; j < 8; j++) src[k].push_back(word(k, j));
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < NUM_LANES; k++)
                for (int j = r*4; j < r*4 + 4; j++) exp_q.push_back({LANE_W'(k), word(k, j)});
        fires = 0;
        multi = 0;
        for (int c = 0; c < 32; c++) begin
            if ($countones(rdy_out) > 1) multi++;
            step(f);
            if (f >= 0) fires++;
        end
        repeat (3) step(f);
        n_tests++;
        if (fires !== 32 || multi !== 0) begin
            n_fail++;
            $display("FAIL rr_no_gaps: %0d transfers, %0d multi-ready cycles, required 32 0", fires, multi);
        end
        n_tests++;
        if (wcnt !== 16'd32) begin
            n_fail++;
            $display("FAIL rr_count: %0d, required 32", wcnt);
        end
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got = 'x;
            if (obs_q.size() > 0) got = obs_q.pop_front();
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL rr_order: got %h required %h", got, want);
            end
        end
    endtask

    task automatic test_backpressure();
        int f;
        logic [LANE_W+DATA_W-1:0] got, want;
        do_reset();
        for (int j = 0; j < 4; j++) begin
            src[0].push_back(word(0, j));
            src[1].push_back(word(1, j));
        end
        for (int j = 0; j < 4; j++) exp_q.push_back({2'd0, word(0, j)});
        for (int j = 0; j < 4; j++) exp_q.push_back({2'd1, word(1, j)});
        step(f);
        step(f);
        rdy_in = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step(f);
            n_tests++;
            if (f !== -1 || rdy_out !== '0 || vout !== 1'b1 || dout !== word(0, 1) || lane_out !== 2'd0) begin
                n_fail++;
                $display("FAIL bp_hold: fired=%0d rdy=%b vout=%b data=%h lane=%0d, required -1 0 1 %h 0",
                         f, rdy_out, vout, dout, lane_out, word(0, 1));
            end
        end
        rdy_in = 1'b1;
        repeat (12) step(f);
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got = 'x;
            if (obs_q.size() > 0) got = obs_q.pop_front();
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL bp_order: got %h required %h", got, want);
            end
        end
        n_tests++;
        if (wcnt !== 16'd8) begin
            n_fail++;
            $display("FAIL bp_count: %0d, required 8", wcnt);
        end
    endtask

    task automatic test_valid_drop();
        int f;
        int fire_tbl [10] = '{1, 1, -1, 3, 3, 3, 3, 0, -1, 2};
        logic [LANE_W+DATA_W-1:0] got, want;
        do_reset();
        for (int j = 0; j < 2; j++) src[1].push_back(word(1, j));
        for (int j = 0; j < 4; j++) src[3].push_back(word(3, j));
        for (int j = 0; j < 2; j++) exp_q.push_back({2'd1, word(1, j)});
        for (int j = 0; j < 4; j++) exp_q.push_back({2'd3, word(3, j)});
        exp_q.push_back({2'd0, word(0, 9)});
        exp_q.push_back({2'd2, word(2, 9)});
        for (int c = 0; c < 10; c++) begin
            if (c == 7) begin
                src[0].push_back(word(0, 9));
                src[2].push_back(word(2, 9));
            end
            step(f);
            n_tests++;
            if (f !== fire_tbl[c]) begin
                n_fail++;
                $display("FAIL drop_grant[%0d]: lane %0d, required %0d", c, f, fire_tbl[c]);
            end
        end
        repeat (3) step(f);
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got = 'x;
            if (obs_q.size() > 0) got = obs_q.pop_front();
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL drop_order: got %h required %h", got, want);
            end
        end
    endtask

    task automatic test_enable_saturate();
        int f, first;
        logic [LANE_W+DATA_W-1:0] got, want;
        do_reset();
        for (int j = 0; j < 8; j++) src[0].push_back(word(0, j));
        for (int j = 0; j < 4; j++) src[1].push_back(word(1, j));
        for (int j = 0; j < 2; j++) exp_q.push_back({2'd0, word(0, j)});
        for (int j = 0; j < 4; j++) exp_q.push_back({2'd1, word(1, j)});
        for (int j = 2; j < 8; j++) exp_q.push_back({2'd0, word(0, j)});
        step(f);
        step(f);
        en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step(f);
            n_tests++;
            if (f !== -1 || rdy_out !== '0) begin
                n_fail++;
                $display("FAIL en_off: fired=%0d rdy=%b, required -1 0", f, rdy_out);
            end
        end
        n_tests++;
        if (vout !== 1'b0 || wcnt !== 16'd2) begin
            n_fail++;
            $display("FAIL en_drain: vout=%b cnt=%0d, required 0 2", vout, wcnt);
        end
        force dut.word_cnt_q = 16'hFFFC;
        @(posedge clk);
        #1;
        release dut.word_cnt_q;
        @(negedge clk);
        en = 1'b1;
        step(first);
        n_tests++;
        if (first !== 1) begin
            n_fail++;
            $display("FAIL en_regrant: lane %0d, required 1", first);
        end
        repeat (20) step(f);
        n_tests++;
        if (wcnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL sat_count: %h, required ffff", wcnt);
        end
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got = 'x;
            if (obs_q.size() > 0) got = obs_q.pop_front();
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL en_order: got %h required %h", got, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_lane();
        test_round_robin();
        test_backpressure();
        test_valid_drop();
        test_enable_saturate();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
